// File: rtl/fixed_point_divider.sv
// Sequential restoring divider: quot = (num << SHIFT) / den, one quotient bit per clock.
// Inverts the multiply-then-right-shift gain stage. Valid/ready handshake on both sides.
// Optional macro DIV_SATURATE_EN: clamp an oversized quotient to all ones and raise sat.
module fixed_point_divider #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero,
  output logic             sat
);

  localparam int unsigned N    = WIDTH + SHIFT;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      dvd_q, dvd_d;
  logic [WIDTH:0]    prem_q, prem_d;
  logic [N-1:0]      qfull_q, qfull_d;
  logic [WIDTH-1:0]  den_q, den_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              sat_q, sat_d;

  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    den_inv;
  logic [WIDTH:0]    trial;
  logic [WIDTH+1:0]  carry;
  logic              take;
  logic [WIDTH:0]    step_rem;
  logic [N-1:0]      step_q;
  // The remainder stays below den, so its top bit never carries information into the shift.
  logic              unused_prem_msb;

  assign unused_prem_msb = prem_q[WIDTH];

  // Subtract step: inverter plus ripple-carry adder of full-adder cells with carry-in 1.
  always_comb begin
    rem_sh   = {prem_q[WIDTH-1:0], dvd_q[N-1]};
    den_inv  = ~{1'b0, den_q};
    carry    = '0;
    trial    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      trial[i]   = rem_sh[i] ^ den_inv[i] ^ carry[i];
      carry[i+1] = (rem_sh[i] & den_inv[i]) | (carry[i] & (rem_sh[i] ^ den_inv[i]));
    end
    // Carry-out set means rem_sh >= den.
    take     = carry[WIDTH+1];
    step_rem = take ? trial : rem_sh;
    step_q   = {qfull_q[N-2:0], take};
  end

  // Next-state logic for the FSM, datapath and result registers.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    qfull_d = qfull_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (den != '0) begin
            dvd_d   = N'(num) << SHIFT;
            prem_d  = '0;
            qfull_d = '0;
            den_d   = den;
            cnt_d   = CntW'(N - 1);
            state_d = StBusy;
          end else begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            sat_d   = 1'b0;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        dvd_d   = dvd_q << 1;
        prem_d  = step_rem;
        qfull_d = step_q;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          rem_d   = step_rem[WIDTH-1:0];
          dbz_d   = 1'b0;
`ifdef DIV_SATURATE_EN
          if (|step_q[N-1:WIDTH]) begin
            quot_d = '1;
            sat_d  = 1'b1;
          end else begin
            quot_d = step_q[WIDTH-1:0];
            sat_d  = 1'b0;
          end
`else
          quot_d  = step_q[WIDTH-1:0];
          sat_d   = 1'b0;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      prem_q  <= '0;
      qfull_q <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      qfull_q <= qfull_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign sat         = sat_q;

endmodule
